// File: rtl/iir_biquad_mc.sv
// Time-multiplexed Direct Form II biquad serving CH channels through one shared datapath.
// Each channel keeps its own w1/w2 delay line; output is registered one cycle after the state update.
module iir_biquad_mc #(
  parameter int W    = 14,
  parameter int FRAC = 11,
  parameter int CH   = 4,
  parameter int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W-1:0]   DIN,
  input  logic           VIN,
  input  logic [CHW-1:0] CH_IN,
  input  logic [W-1:0]   B0,
  input  logic [W-1:0]   B1,
  input  logic [W-1:0]   B2,
  input  logic [W-1:0]   A1,
  input  logic [W-1:0]   A2,
  input  logic           BYPASS,
  input  logic           CLR,
  input  logic [CHW-1:0] CLR_CH,
  output logic [W-1:0]   DOUT,
  output logic           VOUT,
  output logic [CHW-1:0] CH_OUT,
  output logic           SAT,
  input  logic           SAT_CLR
);

  localparam int AW = 2 * W + 2;
  localparam logic signed [AW-1:0] SAT_MAX = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};

  function automatic logic signed [AW-1:0] sx(input logic [W-1:0] v);
    return {{(AW - W){v[W-1]}}, v};
  endfunction

  function automatic logic ovf_w(input logic signed [AW-1:0] x);
    return (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [AW-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[W-1:0];
    if (x < SAT_MIN) return SAT_MIN[W-1:0];
    return x[W-1:0];
  endfunction

  logic signed [W-1:0]  w1_q [CH];
  logic signed [W-1:0]  w2_q [CH];
  logic signed [W-1:0]  w1_d [CH];
  logic signed [W-1:0]  w2_d [CH];

  logic signed [W-1:0]  rd_w1, rd_w2;
  logic                 ch_ok, clr_ok, upd;
  logic signed [AW-1:0] fb, fb_sh, ff, ff_sh;
  logic signed [W-1:0]  w_v, y_v;

  logic                 vld_p1_q, vld_p1_d;
  logic signed [W-1:0]  dout_p1_q, dout_p1_d;
  logic [CHW-1:0]       ch_p1_q, ch_p1_d;
  logic                 sat_ev_p1_q, sat_ev_p1_d;

  logic                 vout_q, vout_d;
  logic signed [W-1:0]  dout_q, dout_d;
  logic [CHW-1:0]       ch_out_q, ch_out_d;
  logic                 sat_q, sat_d;

  assign ch_ok  = 32'(CH_IN) < 32'(CH);
  assign clr_ok = CLR && (32'(CLR_CH) < 32'(CH));
  assign upd    = VIN && ch_ok && !BYPASS;

  // Stage p0: state read (a same-channel clear forces a zero read) and arithmetic
  always_comb begin
    rd_w1 = '0;
    rd_w2 = '0;
    for (int c = 0; c < CH; c++) begin
      if (CH_IN == CHW'(c)) begin
        rd_w1 = w1_q[c];
        rd_w2 = w2_q[c];
      end
    end
    if (clr_ok && (CLR_CH == CH_IN)) begin
      rd_w1 = '0;
      rd_w2 = '0;
    end
  end

  always_comb begin
    fb    = (sx(DIN) <<< FRAC) - sx(A1) * sx(rd_w1) - sx(A2) * sx(rd_w2);
    fb_sh = fb >>> FRAC;
    w_v   = sat_w(fb_sh);
    ff    = sx(B0) * sx(w_v) + sx(B1) * sx(rd_w1) + sx(B2) * sx(rd_w2);
    ff_sh = ff >>> FRAC;
    y_v   = sat_w(ff_sh);
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w1_d[c] = w1_q[c];
      w2_d[c] = w2_q[c];
      if (clr_ok && (CLR_CH == CHW'(c))) begin
        w1_d[c] = '0;
        w2_d[c] = '0;
      end
      if (upd && (CH_IN == CHW'(c))) begin
        w1_d[c] = w_v;
        w2_d[c] = rd_w1;
      end
    end
  end

  always_comb begin
    vld_p1_d    = VIN && ch_ok;
    dout_p1_d   = dout_p1_q;
    ch_p1_d     = ch_p1_q;
    sat_ev_p1_d = upd && (ovf_w(fb_sh) || ovf_w(ff_sh));
    if (vld_p1_d) begin
      dout_p1_d = BYPASS ? $signed(DIN) : y_v;
      ch_p1_d   = CH_IN;
    end
  end

  // Stage p1 -> output registers; saturation set beats a simultaneous clear
  always_comb begin
    vout_d   = vld_p1_q;
    dout_d   = vld_p1_q ? dout_p1_q : dout_q;
    ch_out_d = vld_p1_q ? ch_p1_q : ch_out_q;
    sat_d    = (sat_q && !SAT_CLR) || (vld_p1_q && sat_ev_p1_q);
  end

  always_ff @(posedge CLK) begin
    dout_p1_q   <= dout_p1_d;
    ch_p1_q     <= ch_p1_d;
    sat_ev_p1_q <= sat_ev_p1_d;
    if (RST) begin
      for (int c = 0; c < CH; c++) begin
        w1_q[c] <= '0;
        w2_q[c] <= '0;
      end
      vld_p1_q <= 1'b0;
      vout_q   <= 1'b0;
      dout_q   <= '0;
      ch_out_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        w1_q[c] <= w1_d[c];
        w2_q[c] <= w2_d[c];
      end
      vld_p1_q <= vld_p1_d;
      vout_q   <= vout_d;
      dout_q   <= dout_d;
      ch_out_q <= ch_out_d;
      sat_q    <= sat_d;
    end
  end

  assign DOUT   = dout_q;
  assign VOUT   = vout_q;
  assign CH_OUT = ch_out_q;
  assign SAT    = sat_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc: expected samples are queued at drive time and
// compared when the design presents them two edges later.
module tb_iir_biquad_mc;

  localparam int W   = 14;
  localparam int CHW = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [W-1:0]   DIN = '0;
  logic           VIN = 1'b0;
  logic [CHW-1:0] CH_IN = '0;
  logic [W-1:0]   B0 = '0, B1 = '0, B2 = '0, A1 = '0, A2 = '0;
  logic           BYPASS = 1'b0;
  logic           CLR = 1'b0;
  logic [CHW-1:0] CLR_CH = '0;
  logic [W-1:0]   DOUT;
  logic           VOUT;
  logic [CHW-1:0] CH_OUT;
  logic           SAT;
  logic           SAT_CLR = 1'b0;

  iir_biquad_mc #(.W(W), .FRAC(11), .CH(4)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .CH_IN(CH_IN),
    .B0(B0), .B1(B1), .B2(B2), .A1(A1), .A2(A2),
    .BYPASS(BYPASS), .CLR(CLR), .CLR_CH(CLR_CH),
    .DOUT(DOUT), .VOUT(VOUT), .CH_OUT(CH_OUT), .SAT(SAT), .SAT_CLR(SAT_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int ch;
    int dout;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic prev_push = 1'b0;
  int   last_dout = 0;
  logic byp_r = 1'b0, clr_r = 1'b0, sat_clr_r = 1'b0;
  int   clr_ch_r = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic coef(input int b0, input int b1, input int b2, input int a1, input int a2);
    B0 = b0[W-1:0]; B1 = b1[W-1:0]; B2 = b2[W-1:0]; A1 = a1[W-1:0]; A2 = a2[W-1:0];
  endtask

  task automatic cyc(input logic rst, input logic vin, input int ch, input int din, input int exp);
    logic cur;
    exp_t e;
    RST     = rst;
    VIN     = vin;
    CH_IN   = ch[CHW-1:0];
    DIN     = din[W-1:0];
    BYPASS  = byp_r;
    CLR     = clr_r;
    CLR_CH  = clr_ch_r[CHW-1:0];
    SAT_CLR = sat_clr_r;
    cur = vin && !rst;
    if (cur) q.push_back('{ch, exp});
    @(posedge CLK);
    #1;
    if (rst) begin
      if (prev_push) void'(q.pop_front());
      chk("rst_vout", 32'(VOUT), 0);
      chk("rst_dout", 32'($signed(DOUT)), 0);
      chk("rst_ch_out", 32'(CH_OUT), 0);
      last_dout = 0;
    end else if (prev_push) begin
      e = q.pop_front();
      chk("vout", 32'(VOUT), 1);
      chk("dout", 32'($signed(DOUT)), e.dout);
      chk("ch_out", 32'(CH_OUT), e.ch);
      last_dout = e.dout;
    end else begin
      chk("vout_idle", 32'(VOUT), 0);
      chk("dout_hold", 32'($signed(DOUT)), last_dout);
    end
    prev_push = cur;
    RST = 1'b0; VIN = 1'b0; BYPASS = 1'b0; CLR = 1'b0; SAT_CLR = 1'b0;
    byp_r = 1'b0; clr_r = 1'b0; sat_clr_r = 1'b0;
  endtask

  task automatic smp(input int ch, input int din, input int exp);
    cyc(1'b0, 1'b1, ch, din, exp);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // reset state
    cyc(1'b1, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0, 0);
    chk("rst_sat", 32'(SAT), 0);

    // identity on ch0
    coef(2048, 0, 0, 0, 0);
    smp(0, 100, 100);
    smp(0, -300, -300);
    smp(0, 8191, 8191);
    idle();
    idle();
    chk("ident_sat", 32'(SAT), 0);

    // single-pole impulse on ch1, then bypass mid-decay and resume
    coef(2048, 0, 0, -1024, 0);
    smp(1, 1024, 1024);
    smp(1, 0, 512);
    smp(1, 0, 256);
    smp(1, 0, 128);
    byp_r = 1'b1;
    smp(1, -5, -5);
    smp(1, 0, 64);
    idle();

    // channel isolation on ch0/ch2 after clearing both
    clr_r = 1'b1; clr_ch_r = 0;
    idle();
    clr_r = 1'b1; clr_ch_r = 2;
    idle();
    smp(0, 1024, 1024);
    smp(2, 2000, 2000);
    smp(0, 0, 512);
    smp(2, 0, 1000);
    smp(0, 0, 256);
    smp(2, 0, 500);

    // clear: ch0 cleared alongside a ch3 sample, then same-channel clear on ch3
    clr_r = 1'b1; clr_ch_r = 0;
    smp(3, 1024, 1024);
    clr_r = 1'b1; clr_ch_r = 3;
    smp(3, 0, 0);
    smp(3, 0, 0);
    smp(0, 0, 0);
    idle();

    // output saturation, sticky flag, clear, set-wins
    coef(8191, 0, 0, 0, 0);
    smp(0, 4000, 8191);
    smp(0, 100, 399);
    chk("sat_set", 32'(SAT), 1);
    idle();
    chk("sat_sticky", 32'(SAT), 1);
    sat_clr_r = 1'b1;
    idle();
    chk("sat_clr", 32'(SAT), 0);
    smp(0, 4000, 8191);
    sat_clr_r = 1'b1;
    idle();
    chk("sat_set_wins", 32'(SAT), 1);
    sat_clr_r = 1'b1;
    idle();
    chk("sat_clr2", 32'(SAT), 0);
    smp(0, -4000, -8192);
    idle();
    chk("sat_neg", 32'(SAT), 1);
    sat_clr_r = 1'b1;
    clr_r = 1'b1; clr_ch_r = 2;
    idle();
    chk("sat_clr3", 32'(SAT), 0);

    // saturation of the internal state w only
    coef(256, 0, 0, -8192, 0);
    smp(2, 4000, 500);
    smp(2, 0, 1023);
    chk("w_nosat", 32'(SAT), 0);
    idle();
    chk("w_sat", 32'(SAT), 1);

    // reset the cycle after a VIN drops the pending output and clears all state
    coef(2048, 0, 0, -1024, 0);
    smp(1, 0, 32);
    cyc(1'b1, 1'b0, 0, 0, 0);
    chk("rst_sat_mid", 32'(SAT), 0);
    smp(1, 0, 0);
    smp(3, 1024, 1024);
    smp(3, 0, 512);
    idle();
    idle();
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_biquad_mc.md
Name: iir_biquad_mc

Overview:
Parametrised, time-multiplexed second-order IIR (Direct Form II biquad) serving CH independent channels with one shared arithmetic datapath. Each channel has its own delay-line state. Coefficients are shared and sampled per valid input. Sits between the sample source and sink in the filter chain. It generalises the single-channel fixed-width biquad with these additions:
- channel tagging
- per-channel state clear
- bypass mode
- saturation with a sticky flag

Parameters:
W, 14, data and coefficient width (signed two's complement)
FRAC, 11, coefficient fractional bits (1.0 = 2^FRAC)
CH, 4, number of channels (>=1)
CHW, $clog2(CH) (min 1), channel index width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
DIN  in  W  input sample, signed
VIN  in  1  DIN/CH_IN valid strobe
CH_IN  in  CHW  channel of DIN
B0  in  W  feed-forward coeff b0, signed Q(FRAC)
B1  in  W  feed-forward coeff b1
B2  in  W  feed-forward coeff b2
A1  in  W  feedback coeff a1
A2  in  W  feedback coeff a2
BYPASS  in  1  1: DOUT = DIN, state untouched
CLR  in  1  clear state of channel CLR_CH
CLR_CH  in  CHW  channel to clear
DOUT  out  W  filtered sample, signed
VOUT  out  1  DOUT valid
CH_OUT  out  CHW  channel of DOUT
SAT  out  1  sticky saturation flag
SAT_CLR  in  1  clears SAT

Behaviour:
- Reset (RST=1 at a rising edge):
  - DOUT=0, VOUT=0, CH_OUT=0, SAT=0.
  - All channel states w1[c]=w2[c]=0.
  - Reset overrides every other input in that cycle.
  - Reset mid-stream discards any pending output: VOUT=0 in the cycle after.
- Throughput: one sample per cycle; any channel order, including back-to-back samples on the same channel.
- Latency: exactly 1 cycle. VIN=1 at edge k gives VOUT=1 after edge k+1, with DOUT/CH_OUT for that sample. Otherwise VOUT=0 and DOUT, CH_OUT hold their last values.
- Datapath for VIN=1, BYPASS=0, channel c = CH_IN:
  - fb = DIN*2^FRAC - A1*w1[c] - A2*w2[c]
    - Full precision, 2W+2 bits.
  - w = sat_W(fb >>> FRAC)
    - `>>>` is an arithmetic shift, truncating toward -inf.
  - ff = B0*w + B1*w1[c] + B2*w2[c]
  - DOUT = sat_W(ff >>> FRAC)
  - State update at the same edge: w2[c] <= w1[c]; w1[c] <= w.
  - The next sample on channel c sees the updated state, so there is no hazard.
- sat_W clamps to [-2^(W-1), 2^(W-1)-1]. Any clamp on w or DOUT sets SAT=1 at the output edge.
- SAT behaviour:
  - SAT stays set until SAT_CLR=1 or RST.
  - If SAT_CLR and a new saturation occur in the same cycle, set wins.
- BYPASS=1 with VIN=1:
  - DOUT = DIN and CH_OUT = CH_IN, same 1-cycle latency.
  - No state update and no SAT change.
- CLR=1 zeroes w1[CLR_CH] and w2[CLR_CH] at the edge.
  - CLR with VIN=1 on the same channel and BYPASS=0: clear takes priority. The sample is computed with w1=w2=0, then state becomes w1=w, w2=0.
  - CLR on a different channel: both actions occur independently.
- CH_IN or CLR_CH >= CH (non-power-of-two CH):
  - Sample ignored: no VOUT, no state change.
  - Clear ignored.
- Coefficients are sampled only on VIN=1 cycles. Changing them between samples is legal and takes effect on the next sample.
- State storage: registers or a CH-deep array indexed by channel. Read and write are in the same cycle (read-before-write).

Test Plan:
- Identity: B0=2048, others 0, ch0 DIN=100,-300,8191 -> DOUT=100,-300,8191 one cycle after each VIN; SAT=0.
- Single-pole impulse: B0=2048, A1=-1024 (-0.5), A2=B1=B2=0, ch1 DIN=1024 then 0,0,0 -> DOUT=1024,512,256,128.
- Channel isolation:
  - Setup: same coeffs as the single-pole case; interleave ch0 impulse 1024 and ch2 impulse 2000, with zeros on each channel in alternate cycles.
  - Expected ch0: 1024,512,256.
  - Expected ch2: 2000,1000,500, each with the correct CH_OUT.
- Saturation: B0=8191 (~4.0), ch0 DIN=4000 -> DOUT=8191 and SAT=1 next cycle. SAT persists through later in-range samples; SAT_CLR=1 -> SAT=0.
- Clear and reset:
  - Setup: single-pole setup on ch3 after impulse 1024.
  - CLR=1 on ch3 with VIN=1 and DIN=0 -> DOUT=0; subsequent zeros give 0.
  - RST=1 asserted the cycle after a VIN -> VOUT=0, DOUT=0; all channels restart from zero state.
- Bypass: BYPASS=1, ch1 DIN=-5 during a single-pole decay -> DOUT=-5. After BYPASS=0, ch1 decay continues from its pre-bypass state.
